// File: rtl/accumulator_pkg.sv
// Shared DCIM width constants for the accumulator.
// The accumulator parameters default to these values.
package accumulator_pkg;

    localparam int unsigned DCIM_INPUT_WIDTH  = 27;
    localparam int unsigned DCIM_OUTPUT_WIDTH = 51;
    localparam int unsigned DCIM_CNT_WIDTH    = 8;

endpackage

// File: rtl/accumulator.sv
// MSB-first shift-and-add accumulator with a sticky overflow flag and a saturating step counter.
// Each non-start cycle computes acc = (acc << 1) + psum_in, wrapping modulo 2^OUTPUT_WIDTH.
module accumulator
    import accumulator_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = DCIM_INPUT_WIDTH,
    parameter int unsigned OUTPUT_WIDTH = DCIM_OUTPUT_WIDTH,
    parameter int unsigned CNT_WIDTH    = DCIM_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_acc,
    input  logic [INPUT_WIDTH-1:0]  psum_in,
    output logic [OUTPUT_WIDTH-1:0] nout,
    output logic                    ovf,
    output logic [CNT_WIDTH-1:0]    step_cnt
);

    logic [OUTPUT_WIDTH:0]   sum_c;
    logic [OUTPUT_WIDTH-1:0] acc_next;
    logic                    ovf_next;
    logic [CNT_WIDTH-1:0]    cnt_next;

    // One extra bit on the shift-add exposes the carry out of the accumulator width.
    always_comb begin
        sum_c    = '0;
        acc_next = nout;
        ovf_next = ovf;
        cnt_next = step_cnt;
        if (start_acc) begin
            acc_next = '0;
            ovf_next = 1'b0;
            cnt_next = '0;
        end else begin
            sum_c    = (OUTPUT_WIDTH+1)'({nout[OUTPUT_WIDTH-2:0], 1'b0})
                     + (OUTPUT_WIDTH+1)'(psum_in);
            acc_next = sum_c[OUTPUT_WIDTH-1:0];
            ovf_next = ovf | nout[OUTPUT_WIDTH-1] | sum_c[OUTPUT_WIDTH];
            cnt_next = (step_cnt == {CNT_WIDTH{1'b1}}) ? step_cnt
                                                       : step_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nout     <= '0;
            ovf      <= 1'b0;
            step_cnt <= '0;
        end else begin
            nout     <= acc_next;
            ovf      <= ovf_next;
            step_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_accumulator.sv
// Scoreboard bench for the accumulator: the driver queues expected outputs per edge,
// a monitor pops and compares them shortly after each rising edge.
module tb_accumulator;

    localparam int unsigned IW = 27;
    localparam int unsigned OW = 51;
    localparam int unsigned CW = 8;

    typedef struct packed {
        logic [OW-1:0] nout;
        logic          ovf;
        logic [CW-1:0] cnt;
        logic [15:0]   tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_acc;
    logic [IW-1:0] psum_in;
    logic [OW-1:0] nout;
    logic          ovf;
    logic [CW-1:0] step_cnt;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   tag_n    = 0;

    accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .start_acc (start_acc),
        .psum_in   (psum_in),
        .nout      (nout),
        .ovf       (ovf),
        .step_cnt  (step_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int tag, input longint unsigned act,
                         input longint unsigned req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step %0d: got %0d required %0d", name, tag, act, req);
        end
    endtask

    // Called right after a falling edge: drive, take one rising edge, queue the expectation.
    task automatic step(input logic st, input logic [IW-1:0] p, input logic [OW-1:0] e_nout,
                        input logic e_ovf, input logic [CW-1:0] e_cnt);
        exp_t e;
        start_acc = st;
        psum_in   = p;
        @(posedge clk);
        tag_n++;
        e.nout = e_nout;
        e.ovf  = e_ovf;
        e.cnt  = e_cnt;
        e.tag  = 16'(tag_n);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every output edge that has a queued expectation is compared.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("nout",     int'(e.tag), 64'(nout),     64'(e.nout));
            check("ovf",      int'(e.tag), 64'(ovf),      64'(e.ovf));
            check("step_cnt", int'(e.tag), 64'(step_cnt), 64'(e.cnt));
        end
    end

    initial begin
        longint unsigned m_acc;
        longint unsigned m_sum;
        logic            m_ovf;
        longint unsigned modv;
        longint unsigned pmax;

        rst       = 1'b1;
        start_acc = 1'b0;
        psum_in   = '0;
        #3;
        check("rst_nout", 0, 64'(nout),     64'd0);
        check("rst_ovf",  0, 64'(ovf),      64'd0);
        check("rst_cnt",  0, 64'(step_cnt), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Accumulation before any start proceeds from zero
        step(1'b0, 27'd4, 51'd4, 1'b0, 8'd1);
        step(1'b0, 27'd1, 51'd9, 1'b0, 8'd2);

        // Start then three steps of 24
        step(1'b1, 27'd0,  51'd0,   1'b0, 8'd0);
        step(1'b0, 27'd24, 51'd24,  1'b0, 8'd1);
        step(1'b0, 27'd24, 51'd72,  1'b0, 8'd2);
        step(1'b0, 27'd24, 51'd168, 1'b0, 8'd3);

        // 5, 3, start pulse (psum ignored), then 1
        step(1'b1, 27'd0,  51'd0,  1'b0, 8'd0);
        step(1'b0, 27'd5,  51'd5,  1'b0, 8'd1);
        step(1'b0, 27'd3,  51'd13, 1'b0, 8'd2);
        step(1'b1, 27'd77, 51'd0,  1'b0, 8'd0);
        step(1'b0, 27'd1,  51'd1,  1'b0, 8'd1);

        // start held for three edges
        repeat (3) step(1'b1, 27'd9, 51'd0, 1'b0, 8'd0);

        // Full-scale input for 30 edges against a wide-integer reference
        modv  = 64'd1 << OW;
        pmax  = (64'd1 << IW) - 64'd1;
        m_acc = 0;
        m_ovf = 1'b0;
        step(1'b1, 27'd0, 51'd0, 1'b0, 8'd0);
        for (int i = 1; i <= 30; i++) begin
            m_sum = m_acc * 2 + pmax;
            if (m_sum >= modv) m_ovf = 1'b1;
            m_acc = m_sum % modv;
            step(1'b0, IW'(pmax), OW'(m_acc), m_ovf, CW'(i));
        end

        // Async reset mid-accumulation, sticky ovf cleared by start first
        step(1'b1, 27'd0,   51'd0,   1'b0, 8'd0);
        step(1'b0, 27'd100, 51'd100, 1'b0, 8'd1);
        step(1'b0, 27'd3,   51'd203, 1'b0, 8'd2);
        #2 rst = 1'b1;
        #1;
        check("async_nout", tag_n, 64'(nout),     64'd0);
        check("async_ovf",  tag_n, 64'(ovf),      64'd0);
        check("async_cnt",  tag_n, 64'(step_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 27'd7, 51'd7,  1'b0, 8'd1);
        step(1'b0, 27'd1, 51'd15, 1'b0, 8'd2);

        // Step counter saturates at 255 with zero input
        step(1'b1, 27'd0, 51'd0, 1'b0, 8'd0);
        for (int i = 1; i <= 300; i++)
            step(1'b0, 27'd0, 51'd0, 1'b0, CW'((i > 255) ? 255 : i));

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
